// File: rtl/hmac_top.sv
// Simplified PUF-keyed MAC engine: derives a 512-bit key from a PUF response and
// folds a 32-bit word stream into an ipad/opad-masked state. Optional macro: HMAC_MSG_LEN_EN.
module hmac_top (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_puf,
  input  logic         start_hmac,
  input  logic [703:0] puf_input,
  input  logic [31:0]  msg_word,
  input  logic         msg_valid,
  input  logic         msg_last,
  output logic         msg_ready,
  output logic [511:0] puf_key,
  output logic [511:0] hmac_value,
  output logic         done
);

  localparam logic [511:0] IPAD = {64{8'h36}};
  localparam logic [511:0] OPAD = {64{8'h5c}};

  typedef enum logic [2:0] {IDLE, PUF, MSG, FINAL, DONE} state_t;

  state_t       state_reg, state_next;
  logic [511:0] s_reg;
  logic [511:0] puf_key_reg;
  logic [511:0] hmac_reg;
  logic [511:0] puf_fold;
  logic [511:0] mac_next;
  logic [511:0] len_fold;
  logic         accept;
  logic         hmac_entry;

  assign msg_ready  = (state_reg == MSG);
  assign accept     = msg_valid && msg_ready;
  assign hmac_entry = (state_reg == IDLE) && !start_puf && start_hmac;
  assign done       = (state_reg == DONE);
  assign puf_key    = puf_key_reg;
  assign hmac_value = hmac_reg;
  assign puf_fold   = puf_input[511:0] ^ {320'b0, puf_input[703:512]};

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start_puf)       state_next = PUF;
        else if (start_hmac) state_next = MSG;
      end
      PUF:     state_next = DONE;
      MSG:     if (accept && msg_last) state_next = FINAL;
      FINAL:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef HMAC_MSG_LEN_EN
  logic [15:0] cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (hmac_entry) begin
      cnt_reg <= '0;
    end else if (accept) begin
      cnt_reg <= cnt_reg + 16'd1;
    end
  end

  assign len_fold = {496'b0, cnt_reg};
`else
  assign len_fold = '0;
`endif

  // Outer masking is applied lane by lane; the length fold only touches the low lane.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_lane
      assign mac_next[gi*32 +: 32] = s_reg[gi*32 +: 32] ^ puf_key_reg[gi*32 +: 32]
                                   ^ OPAD[gi*32 +: 32] ^ len_fold[gi*32 +: 32];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      s_reg       <= '0;
      puf_key_reg <= '0;
      hmac_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (hmac_entry) s_reg <= puf_key_reg ^ IPAD;
      if (state_reg == PUF) puf_key_reg <= puf_fold;
      // Each accepted word rotates the state left by one lane and mixes into the new low lane.
      if (accept) s_reg <= {s_reg[479:0], s_reg[511:480] ^ msg_word};
      if (state_reg == FINAL) hmac_reg <= mac_next;
    end
  end

endmodule

// File: tb/tb_hmac_top.sv
// Randomised scoreboard bench for hmac_top: a driver pushes expected results,
// a negedge monitor pops them on every done pulse and checks value and latency.
module tb_hmac_top;

  logic         clk = 1'b0;
  logic         reset;
  logic         start_puf, start_hmac;
  logic [703:0] puf_input;
  logic [31:0]  msg_word;
  logic         msg_valid, msg_last;
  logic         msg_ready;
  logic [511:0] puf_key, hmac_value;
  logic         done;

  hmac_top dut (
    .clk        (clk),
    .reset      (reset),
    .start_puf  (start_puf),
    .start_hmac (start_hmac),
    .puf_input  (puf_input),
    .msg_word   (msg_word),
    .msg_valid  (msg_valid),
    .msg_last   (msg_last),
    .msg_ready  (msg_ready),
    .puf_key    (puf_key),
    .hmac_value (hmac_value),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           is_mac;
    logic [511:0] val;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  int           cyc = 0;
  int           n_checks = 0;
  int           n_pass = 0;
  int           acc_cnt = 0;
  logic [511:0] model_key = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: the key is the low 512 PUF bits XOR the upper 192 bits.
  function automatic logic [511:0] puf_model(input logic [703:0] v);
    logic [511:0] hi;
    hi = '0;
    hi[191:0] = v[703:512];
    return v[511:0] ^ hi;
  endfunction

  // Reference: state kept as a queue of 16 lanes, most significant first;
  // each word pops the top lane and appends (top ^ word) at the bottom.
  function automatic logic [511:0] mac_model(input logic [511:0] key, input logic [31:0] words[$]);
    logic [31:0]  lanes[$];
    logic [511:0] start, r;
    logic [31:0]  t;
    start = key ^ {64{8'h36}};
    for (int i = 0; i < 16; i++) lanes.push_back(start[511-32*i -: 32]);
    foreach (words[i]) begin
      t = lanes.pop_front();
      lanes.push_back(t ^ words[i]);
    end
    for (int i = 0; i < 16; i++) r[511-32*i -: 32] = lanes[i];
    r = r ^ key ^ {64{8'h5c}};
`ifdef HMAC_MSG_LEN_EN
    r[15:0] = r[15:0] ^ 16'(words.size());
`endif
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (msg_valid && msg_ready) acc_cnt = acc_cnt + 1;
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 512'(done), 512'd0);
        end else begin
          e = sb.pop_front();
          chk("done_latency", 512'(cyc), 512'(e.cyc));
          if (e.is_mac) chk("hmac_value", hmac_value, e.val);
          else          chk("puf_key", puf_key, e.val);
        end
      end
    end
  end

  task automatic do_puf(input logic [703:0] v, input bit also_hmac);
    logic [703:0] rnd;
    @(posedge clk); #1;
    puf_input  = v;
    start_puf  = 1'b1;
    start_hmac = also_hmac;
    model_key  = puf_model(v);
    sb.push_back('{is_mac: 1'b0, val: model_key, cyc: cyc + 2});
    @(posedge clk); #1;
    start_puf  = 1'b0;
    start_hmac = 1'b0;
    chk("ready_low_in_puf", 512'(msg_ready), 512'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 22; i++) rnd[i*32 +: 32] = $urandom;
    puf_input = rnd;
    @(posedge clk); #1;
    chk("ready_low_idle", 512'(msg_ready), 512'd0);
  endtask

  task automatic do_mac(input logic [31:0] words[$], input int max_gap);
    @(posedge clk); #1;
    start_hmac = 1'b1;
    @(posedge clk); #1;
    start_hmac = 1'b0;
    chk("ready_high_in_msg", 512'(msg_ready), 512'd1);
    acc_cnt = 0;
    foreach (words[i]) begin
      repeat ($urandom_range(0, max_gap)) begin
        msg_valid = 1'b0;
        msg_last  = 1'($urandom % 2);
        msg_word  = $urandom;
        start_puf = ($urandom % 4 == 0);
        @(posedge clk); #1;
      end
      start_puf = 1'b0;
      msg_valid = 1'b1;
      msg_word  = words[i];
      msg_last  = (i == words.size() - 1);
      if (msg_last) sb.push_back('{is_mac: 1'b1, val: mac_model(model_key, words), cyc: cyc + 2});
      @(posedge clk); #1;
    end
    msg_valid = 1'b0;
    msg_last  = 1'b0;
    chk("ready_low_in_final", 512'(msg_ready), 512'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("words_accepted", 512'(acc_cnt), 512'(words.size()));
  endtask

  initial begin
    logic [31:0]  w[$];
    logic [703:0] v;
    int           guard;
    reset = 1'b1;
    start_puf = 1'b0; start_hmac = 1'b0;
    puf_input = '0; msg_word = '0; msg_valid = 1'b0; msg_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_puf_key", puf_key, '0);
    chk("rst_hmac", hmac_value, '0);
    chk("rst_done", 512'(done), 512'd0);
    chk("rst_ready", 512'(msg_ready), 512'd0);
    reset = 1'b0;

    w = '{32'hDEADBEEF};
    do_mac(w, 0);
`ifdef HMAC_MSG_LEN_EN
    chk("single_word_literal", hmac_value, {{60{8'h6A}}, 32'hB4C7D484});
`else
    chk("single_word_literal", hmac_value, {{60{8'h6A}}, 32'hB4C7D485});
`endif

    w = '{32'hDEADBEEF, 32'hCAFEBABE, 32'h00000011};
    do_mac(w, 0);

    w = '{32'h01234567, 32'h89ABCDEF};
    do_mac(w, 5);

    v = {192'h1, 512'h2};
    do_puf(v, 1'b0);
    chk("puf_literal", puf_key, 512'h3);

    for (int i = 0; i < 22; i++) v[i*32 +: 32] = $urandom;
    do_puf(v, 1'b1);

    for (int it = 0; it < 12; it++) begin
      if ($urandom % 3 == 0) begin
        for (int i = 0; i < 22; i++) v[i*32 +: 32] = $urandom;
        do_puf(v, 1'($urandom % 2));
      end else begin
        w = {};
        repeat ($urandom_range(1, 20)) w.push_back($urandom);
        do_mac(w, 3);
      end
    end

    // Abort in the middle of a message: everything returns to zero, no done pulse.
    @(posedge clk); #1;
    start_hmac = 1'b1;
    @(posedge clk); #1;
    start_hmac = 1'b0;
    msg_valid  = 1'b1;
    msg_word   = 32'h55AA55AA;
    @(posedge clk); #1;
    msg_valid  = 1'b0;
    reset      = 1'b1;
    #2;
    chk("abort_puf_key", puf_key, '0);
    chk("abort_hmac", hmac_value, '0);
    chk("abort_ready", 512'(msg_ready), 512'd0);
    chk("abort_done", 512'(done), 512'd0);
    repeat (2) @(posedge clk);
    #1;
    reset     = 1'b0;
    model_key = '0;
    repeat (4) @(posedge clk);
    #1;
    chk("post_abort_ready", 512'(msg_ready), 512'd0);

    w = '{32'hDEADBEEF};
    do_mac(w, 2);
    v = {192'hABC, 512'h123};
    do_puf(v, 1'b0);

    guard = 0;
    while (sb.size() != 0 && guard < 50) begin
      @(posedge clk);
      guard++;
    end
    chk("scoreboard_drained", 512'(sb.size()), 512'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hmac_top.md
HMAC_TOP -- requirements
Module: hmac_top

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports: clk  in  1  rising-edge clock; reset  in  1  asynchronous active-high reset.
REQ-002 The block SHALL have port start_puf  in  1  one-cycle request to derive the key from puf_input.
REQ-003 The block SHALL have port start_hmac  in  1  one-cycle request to begin a message MAC.
REQ-004 The block SHALL have port puf_input  in  704  PUF response; sampled only in state PUF.
REQ-005 The block SHALL have ports msg_word  in  32  message word; msg_valid  in  1  word present; msg_last  in  1  final word marker.
REQ-006 The block SHALL have port msg_ready  out  1  high exactly while in state MSG.
REQ-007 The block SHALL have ports puf_key  out  512  registered key; hmac_value  out  512  registered MAC.
REQ-008 The block SHALL have port done  out  1  single-cycle completion pulse.

Function
REQ-009 The FSM SHALL have states IDLE, PUF, MSG, FINAL and DONE.
REQ-010 In IDLE, start_puf SHALL move to PUF; otherwise start_hmac SHALL move to MSG; start_puf SHALL win when both are high.
REQ-011 Starts outside IDLE SHALL be ignored.
REQ-012 PUF SHALL load puf_key = puf_input[511:0] XOR zero-extended puf_input[703:512], then go to DONE.
REQ-013 On entry to MSG, the state register S (512 bits) SHALL be loaded with puf_key XOR {64{8'h36}}, and the 16-bit word counter SHALL be cleared.
REQ-014 A word SHALL be accepted when msg_valid and msg_ready are both high.
REQ-015 On acceptance, S SHALL become {S[479:0], S[511:480] XOR msg_word}, and the counter SHALL increment, wrapping modulo 2^16.
REQ-016 Accepting a word with msg_last high SHALL move to FINAL; msg_last without msg_valid SHALL be ignored.
REQ-017 FINAL SHALL load hmac_value = S XOR (puf_key XOR {64{8'h5c}}), with the optional length fold (REQ-023), then go to DONE.
REQ-018 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-019 Latency from start_puf to done SHALL be 2 cycles; from the last-word handshake to done, 2 cycles.
REQ-020 An HMAC run before any PUF run SHALL use the reset key (zero).
REQ-021 puf_key and hmac_value SHALL hold their values until the next PUF or FINAL update, respectively.

Reset
REQ-022 Reset SHALL force: state IDLE; S, counter, puf_key and hmac_value zero; done and msg_ready low. Reset mid-operation SHALL abort with no done pulse.

Configuration
REQ-023 With macro HMAC_MSG_LEN_EN defined, FINAL SHALL additionally XOR the 16-bit word count into hmac_value[15:0]; without it, no count is folded and the counter may be omitted.

Verification
REQ-024 Bench SHALL drive puf_input = {192'h1, 512'h2}, pulse start_puf -> puf_key = 512'h3, and done SHALL pulse once, 2 cycles later.
REQ-025 Bench SHALL, after reset with key 0, pulse start_hmac and send word 32'hDEADBEEF with last set -> hmac_value = 480 bits of 0x6A bytes followed by 32'hB4C7D485 (32'hB4C7D484 with HMAC_MSG_LEN_EN).
REQ-026 Bench SHALL, with key 0, send three words DEADBEEF, CAFEBABE, 00000011 (last on the third) -> msg_ready is high only in MSG, exactly 3 words are accepted, and done pulses once.
REQ-027 Bench SHALL raise start_puf and start_hmac together in IDLE -> the PUF path is taken and msg_ready stays low.
REQ-028 Bench SHALL assert reset during MSG -> all outputs are zero, the FSM is in IDLE, and no done pulse occurs.
REQ-029 Bench SHALL hold msg_valid low for several cycles in MSG -> S and the counter are unchanged and no done pulse occurs.
